transmissao_medidas_multicanal: RTL and testbench

TRANSMISSAO_MEDIDAS_MULTICANAL -- requirements
Module: transmissao_medidas_multicanal

---
 rtl/transmissao_pkg.sv | 24 ++
 rtl/transmissao_medidas_multicanal_conversor_bcd.sv | 77 +++++++
 rtl/transmissao_medidas_multicanal.sv | 115 +++++++++++
 tb/tb_transmissao_medidas_multicanal.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/transmissao_pkg.sv
// Shared definitions for the multichannel measurement transmitter:
// FSM state codes and the ASCII bytes placed on the UART.
package transmissao_pkg;

    typedef enum logic [3:0] {
        IDLE             = 4'd0,
        CAPTURA          = 4'd1,
        CONVERTE         = 4'd2,
        ESPERA_CONVERTE  = 4'd3,
        TRANSMITE_DIGITO = 4'd4,
        ESPERA_DIGITO    = 4'd5,
        PROXIMO_DIGITO   = 4'd6,
        TRANSMITE_SEP    = 4'd7,
        ESPERA_SEP       = 4'd8,
        PROXIMO_CANAL    = 4'd9,
        FIM              = 4'd10
    } estado_t;

    localparam logic [7:0] ASCII_ZERO        = 8'h30;
    localparam logic [7:0] ASCII_NOVE        = 8'h39;
    localparam logic [7:0] SEPARADOR_PADRAO  = 8'h2C;
    localparam logic [7:0] TERMINADOR_PADRAO = 8'h23;

endpackage

// File: rtl/transmissao_medidas_multicanal_conversor_bcd.sv
// Sequential shift-add-3 binary to BCD converter. pronto pulses LARGURA+1
// cycles after inicia; bcd holds the result until the next inicia.
module conversor_bcd #(
    parameter int LARGURA = 12,
    parameter int DIGITOS = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   inicia,
    input  logic [LARGURA-1:0]     binario,
    output logic [4*DIGITOS-1:0]   bcd,
    output logic                   pronto
);

    localparam int NB = 4 * DIGITOS;
    localparam int CW = $clog2(LARGURA + 1);

    logic [LARGURA-1:0] bin_q, bin_d;
    logic [NB-1:0]      bcd_q, bcd_d, ajuste;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               ativo_q, ativo_d, pronto_q, pronto_d, ovf_q, ovf_d;

    always_comb begin
        ajuste = bcd_q;
        for (int i = 0; i < DIGITOS; i++)
            if (bcd_q[4*i +: 4] >= 4'd5) ajuste[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end

    always_comb begin
        bin_d    = bin_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        ativo_d  = ativo_q;
        ovf_d    = ovf_q;
        pronto_d = 1'b0;
        if (inicia) begin
            bin_d   = binario;
            bcd_d   = '0;
            cnt_d   = CW'(LARGURA);
            ativo_d = 1'b1;
            ovf_d   = 1'b0;
        end else if (ativo_q) begin
            // a bit falling off the top digit means the value does not fit
            ovf_d = ovf_q | ajuste[NB-1];
            bcd_d = {ajuste[NB-2:0], bin_q[LARGURA-1]};
            bin_d = bin_q << 1;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                ativo_d  = 1'b0;
                pronto_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bin_q    <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            ativo_q  <= 1'b0;
            pronto_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            bin_q    <= bin_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            ativo_q  <= ativo_d;
            pronto_q <= pronto_d;
            ovf_q    <= ovf_d;
        end
    end

    // overflow forces the top digit nonzero so the consumer saturates
    assign bcd    = {bcd_q[NB-1 -: 4] | {3'b000, ovf_q}, bcd_q[NB-5:0]};
    assign pronto = pronto_q;

endmodule

// File: rtl/transmissao_medidas_multicanal.sv
// Snapshots N_CANAIS binary measurements and sends them over a UART as fixed
// width decimal ASCII fields, separated by SEPARADOR and ended by TERMINADOR.
module transmissao_medidas_multicanal
    import transmissao_pkg::*;
#(
    parameter int         N_CANAIS   = 2,
    parameter int         LARGURA    = 12,
    parameter int         DIGITOS    = 4,
    parameter logic [7:0] SEPARADOR  = SEPARADOR_PADRAO,
    parameter logic [7:0] TERMINADOR = TERMINADOR_PADRAO
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        transmite,
    input  logic [N_CANAIS*LARGURA-1:0] medidas,
    input  logic                        tx_pronto,
    output logic                        tx_partida,
    output logic [7:0]                  tx_dado,
    output logic                        ocupado,
    output logic                        pronto,
    output logic [3:0]                  db_estado
);

    localparam int NB = 4 * (DIGITOS + 1);

    estado_t                       estado_q, estado_d;
    logic [N_CANAIS*LARGURA-1:0]   snap_q, snap_d;
    logic [2:0]                    indice_q, indice_d, digito_q, digito_d;
    logic [7:0]                    tx_dado_q, tx_dado_d;
    logic [LARGURA-1:0]            canal_atual;
    logic [NB-1:0]                 conv_bcd;
    logic                          conv_pronto, ultimo, saturado;

    assign canal_atual = snap_q[int'(indice_q)*LARGURA +: LARGURA];
    assign ultimo      = (indice_q == 3'(N_CANAIS - 1));
    assign saturado    = |conv_bcd[NB-1 -: 4];

    conversor_bcd #(.LARGURA(LARGURA), .DIGITOS(DIGITOS + 1)) u_conv (
        .clock  (clock),
        .reset  (reset),
        .inicia (estado_q == CONVERTE),
        .binario(canal_atual),
        .bcd    (conv_bcd),
        .pronto (conv_pronto)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) estado_q <= IDLE;
        else       estado_q <= estado_d;
    end

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            IDLE:             if (transmite) estado_d = CAPTURA;
            CAPTURA:          estado_d = CONVERTE;
            CONVERTE:         estado_d = ESPERA_CONVERTE;
            ESPERA_CONVERTE:  if (conv_pronto) estado_d = TRANSMITE_DIGITO;
            TRANSMITE_DIGITO: estado_d = ESPERA_DIGITO;
            ESPERA_DIGITO:    if (tx_pronto) estado_d = PROXIMO_DIGITO;
            PROXIMO_DIGITO:   estado_d = (digito_q == 3'd0) ? TRANSMITE_SEP : TRANSMITE_DIGITO;
            TRANSMITE_SEP:    estado_d = ESPERA_SEP;
            ESPERA_SEP:       if (tx_pronto) estado_d = ultimo ? FIM : PROXIMO_CANAL;
            PROXIMO_CANAL:    estado_d = CONVERTE;
            FIM:              estado_d = IDLE;
            default:          estado_d = IDLE;
        endcase
    end

    always_comb begin
        tx_partida = (estado_q == TRANSMITE_DIGITO) || (estado_q == TRANSMITE_SEP);
        ocupado    = (estado_q != IDLE);
        pronto     = (estado_q == FIM);
        db_estado  = estado_q;
        tx_dado    = tx_dado_q;
    end

    // tx_dado is loaded on entry to a TRANSMITE state so the byte is already
    // registered during the tx_partida cycle
    always_comb begin
        logic [3:0] dig;
        snap_d    = snap_q;
        indice_d  = indice_q;
        digito_d  = digito_q;
        tx_dado_d = tx_dado_q;
        dig       = 4'd0;
        if (estado_q == CAPTURA) begin
            snap_d   = medidas;
            indice_d = 3'd0;
        end
        if (estado_q == PROXIMO_CANAL) indice_d = indice_q + 3'd1;
        if (estado_q == ESPERA_CONVERTE) digito_d = 3'(DIGITOS - 1);
        if (estado_q == PROXIMO_DIGITO && digito_q != 3'd0) digito_d = digito_q - 3'd1;
        if (estado_d == TRANSMITE_DIGITO) begin
            dig       = conv_bcd[int'(digito_d)*4 +: 4];
            tx_dado_d = saturado ? ASCII_NOVE : ASCII_ZERO + {4'h0, dig};
        end
        if (estado_d == TRANSMITE_SEP) tx_dado_d = ultimo ? TERMINADOR : SEPARADOR;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            snap_q    <= '0;
            indice_q  <= '0;
            digito_q  <= '0;
            tx_dado_q <= '0;
        end else begin
            snap_q    <= snap_d;
            indice_q  <= indice_d;
            digito_q  <= digito_d;
            tx_dado_q <= tx_dado_d;
        end
    end

endmodule

// File: tb/tb_transmissao_medidas_multicanal.sv
// Directed bench: three configurations (default, DIGITOS=3, N_CANAIS=1), each
// served by a UART model that records bytes and answers tx_pronto after a delay.
module tb_transmissao_medidas_multicanal;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tr   [3];
    logic [23:0] med  [3];
    logic        txp  [3];
    logic        part [3];
    logic [7:0]  dado [3];
    logic        ocup [3];
    logic        pr   [3];
    logic [3:0]  est  [3];

    int          dly      [3];
    bit          stray_en [3];
    bit          waiting  [3];
    int          cnt      [3];
    logic [7:0]  held     [3];
    logic [7:0]  got      [3][64];
    int          got_n    [3];
    int          pr_cnt   [3];
    int          stable_err = 0;
    int          n_chk = 0, n_fail = 0;

    typedef struct {
        int          d;
        logic [23:0] med;
        int          dly;
        string       exp;
    } vec_t;
    vec_t vt [9];

    always #5 clk = ~clk;

    transmissao_medidas_multicanal u_a (
        .clock(clk), .reset(rst), .transmite(tr[0]), .medidas(med[0]), .tx_pronto(txp[0]),
        .tx_partida(part[0]), .tx_dado(dado[0]), .ocupado(ocup[0]), .pronto(pr[0]), .db_estado(est[0]));

    transmissao_medidas_multicanal #(.DIGITOS(3)) u_b (
        .clock(clk), .reset(rst), .transmite(tr[1]), .medidas(med[1]), .tx_pronto(txp[1]),
        .tx_partida(part[1]), .tx_dado(dado[1]), .ocupado(ocup[1]), .pronto(pr[1]), .db_estado(est[1]));

    transmissao_medidas_multicanal #(.N_CANAIS(1)) u_c (
        .clock(clk), .reset(rst), .transmite(tr[2]), .medidas(med[2][11:0]), .tx_pronto(txp[2]),
        .tx_partida(part[2]), .tx_dado(dado[2]), .ocupado(ocup[2]), .pronto(pr[2]), .db_estado(est[2]));

    // UART model: records each started byte, checks it stays put while waiting
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (txp[d]) txp[d] = 1'b0;
            if (rst) begin
                waiting[d] = 1'b0;
            end else if (part[d]) begin
                if (got_n[d] < 64) got[d][got_n[d]] = dado[d];
                got_n[d]++;
                held[d]    = dado[d];
                cnt[d]     = dly[d];
                waiting[d] = 1'b1;
                if (stray_en[d]) txp[d] = 1'b1;
            end else if (waiting[d]) begin
                if (dado[d] !== held[d]) stable_err++;
                cnt[d]--;
                if (cnt[d] <= 0) begin
                    txp[d]     = 1'b1;
                    waiting[d] = 1'b0;
                end
            end
            if (pr[d] === 1'b1) pr_cnt[d]++;
        end
    end

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic set_vec(input int i, input int d, input logic [23:0] m, input int dl, input string e);
        vt[i].d = d; vt[i].med = m; vt[i].dly = dl; vt[i].exp = e;
    endtask

    task automatic start(input int d, input logic [23:0] m, input int dl, input bit stray);
        @(negedge clk);
        med[d] = m; dly[d] = dl; stray_en[d] = stray;
        got_n[d] = 0; pr_cnt[d] = 0; waiting[d] = 1'b0; txp[d] = 1'b0;
        tr[d] = 1'b1;
        @(negedge clk);
        tr[d] = 1'b0;
    endtask

    task automatic finish(input int d, input string exp, input string nm);
        int    k;
        bit    ok;
        string gs;
        k = 0;
        while (ocup[d] && k < 3000) begin
            @(negedge clk);
            k++;
        end
        chk({nm, " back to idle"}, int'(ocup[d]), 0);
        ok = (got_n[d] == exp.len());
        gs = "";
        for (int i = 0; i < got_n[d] && i < 64; i++) begin
            gs = $sformatf("%s%c", gs, got[d][i]);
            if (i < exp.len() && got[d][i] != exp[i]) ok = 1'b0;
        end
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s bytes: got \"%s\" (%0d bytes), required \"%s\"", nm, gs, got_n[d], exp);
        end
        chk({nm, " pronto pulses"}, pr_cnt[d], 1);
    endtask

    initial begin
        int k;
        for (int d = 0; d < 3; d++) begin
            tr[d] = 1'b0; med[d] = '0; txp[d] = 1'b0; dly[d] = 3; stray_en[d] = 1'b0;
            got_n[d] = 0; pr_cnt[d] = 0; waiting[d] = 1'b0; cnt[d] = 0; held[d] = '0;
        end

        set_vec(0, 0, {12'd4095, 12'd123}, 3, "0123,4095#");
        set_vec(1, 0, {12'd0,    12'd0},   1, "0000,0000#");
        set_vec(2, 0, {12'd5,    12'd1000},2, "1000,0005#");
        set_vec(3, 0, {12'd9,    12'd4000},4, "4000,0009#");
        set_vec(4, 1, {12'd0,    12'd1234},3, "999,000#");
        set_vec(5, 1, {12'd1000, 12'd999}, 1, "999,999#");
        set_vec(6, 1, {12'd7,    12'd500}, 2, "500,007#");
        set_vec(7, 2, {12'd0,    12'd7},   3, "0007#");
        set_vec(8, 2, {12'd0,    12'd4095},2, "4095#");

        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset dut%0d state", d),      int'(est[d]),  0);
            chk($sformatf("reset dut%0d tx_dado", d),    int'(dado[d]), 0);
            chk($sformatf("reset dut%0d busy/start", d), int'({ocup[d], part[d], pr[d]}), 0);
        end
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            start(vt[i].d, vt[i].med, vt[i].dly, 1'b0);
            finish(vt[i].d, vt[i].exp, $sformatf("vec%0d", i));
        end

        // new inputs and a second request mid-frame must not alter or queue anything
        start(0, {12'd4095, 12'd123}, 3, 1'b0);
        repeat (12) @(negedge clk);
        med[0] = {12'd1, 12'd2};
        tr[0]  = 1'b1;
        @(negedge clk);
        tr[0]  = 1'b0;
        finish(0, "0123,4095#", "midframe");
        repeat (40) @(negedge clk);
        chk("midframe no second frame", got_n[0], 10);
        chk("midframe idle after", int'(est[0]), 0);

        // slow UART plus a stray done pulse in every TRANSMITE cycle
        stable_err = 0;
        start(0, {12'd42, 12'd3001}, 50, 1'b1);
        finish(0, "3001,0042#", "slow");
        chk("slow tx_dado stable while waiting", stable_err, 0);

        // reset while waiting for the third byte
        start(0, {12'd4095, 12'd123}, 5, 1'b0);
        k = 0;
        while (got_n[0] < 3 && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk("abort third byte reached", got_n[0], 3);
        @(negedge clk);
        chk("abort waiting in ESPERA_DIGITO", int'(est[0]), 5);
        rst = 1'b1;
        #1;
        chk("abort state idle", int'(est[0]), 0);
        chk("abort tx_partida low", int'(part[0]), 0);
        chk("abort ocupado low", int'(ocup[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        chk("abort no pronto", pr_cnt[0], 0);
        chk("abort no further bytes", got_n[0], 3);
        start(0, {12'd4095, 12'd123}, 3, 1'b0);
        finish(0, "0123,4095#", "after abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, required finish");
        $fatal(1);
    end

endmodule
